regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single write port among N writeback requesters, e.g. ALU result, load data and JAL link.

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_wb_pkg;

   localparam int DEF_ADR_W  = 5;
   localparam int DEF_DATA_W = 32;

   localparam logic [DEF_ADR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [DEF_ADR_W-1:0]  adr;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter: searches req from ptr upward, wrapping modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant
);

   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among N_REQ writeback requesters via one-entry slots.
// Optional macro WB_BYPASS_EN adds a combinational forwarding lookup (lookup_adr/fwd_hit/fwd_data).
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADR_W  = DEF_ADR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*ADR_W-1:0]  req_adr,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic                    rf_we,
   output logic [ADR_W-1:0]        rf_wadr,
   output logic [DATA_W-1:0]       rf_wdata,
   output logic                    busy,
   output logic [CNT_W-1:0]        conflict_cnt
`ifdef WB_BYPASS_EN
  ,input  logic [ADR_W-1:0]        lookup_adr
  ,output logic                    fwd_hit
  ,output logic [DATA_W-1:0]       fwd_data
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADR_W-1:0] R0 = ADR_W'(ZERO_REG);

   logic [N_REQ-1:0]  pend_p0;
   logic [ADR_W-1:0]  slot_adr_p0  [N_REQ];
   logic [DATA_W-1:0] slot_data_p0 [N_REQ];
   logic [N_REQ-1:0]  same_mask, arb_req, grant, accept;
   logic [PTR_W-1:0]  rr_ptr, grant_idx;
   logic [ADR_W-1:0]  g_adr;
   logic [DATA_W-1:0] g_data;
   logic              any_grant, multi_pend;

   // A slot shadowed by a lower-index pending slot with the same address waits its turn,
   // so writes to one register leave in index order and the highest index lands last.
   always_comb begin
      same_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (j < i && pend_p0[i] && pend_p0[j] && slot_adr_p0[i] == slot_adr_p0[j])
               same_mask[i] = 1'b1;
         end
      end
   end

   assign arb_req = pend_p0 & ~same_mask;

   rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
      .req   (arb_req),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      grant_idx = '0;
      g_adr     = '0;
      g_data    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PTR_W'(i);
            g_adr     = slot_adr_p0[i];
            g_data    = slot_data_p0[i];
         end
      end
   end

   assign any_grant  = |grant;
   assign multi_pend = ($countones(pend_p0) >= 2);
   assign req_ready  = ~pend_p0 | grant;
   assign accept     = req_valid & req_ready;
   assign busy       = |pend_p0;

   // Slot stage: pending flags, pointer, output stage and counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_p0      <= '0;
         rr_ptr       <= '0;
         rf_we        <= 1'b0;
         rf_wadr      <= '0;
         rf_wdata     <= '0;
         conflict_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (accept[i])
               pend_p0[i] <= (req_adr[i*ADR_W +: ADR_W] != R0);
            else if (grant[i])
               pend_p0[i] <= 1'b0;
         end
         rf_we <= any_grant;
         if (any_grant) begin
            rf_wadr  <= g_adr;
            rf_wdata <= g_data;
            rr_ptr   <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
         end
         if (multi_pend && !(&conflict_cnt))
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i]) begin
            slot_adr_p0[i]  <= req_adr[i*ADR_W +: ADR_W];
            slot_data_p0[i] <= req_data[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Later (higher-index) pending matches override earlier ones and the output stage.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (lookup_adr != R0) begin
         if (rf_we && rf_wadr == lookup_adr) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_wdata;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (pend_p0[i] && slot_adr_p0[i] == lookup_adr) begin
               fwd_hit  = 1'b1;
               fwd_data = slot_data_p0[i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic vs a slot-level model.
module tb_regfile_wb_arbiter;
   import regfile_wb_pkg::*;

   localparam int N = 3;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*AW-1:0] req_adr;
   logic [N*DW-1:0] req_data;
   logic            rf_we, busy;
   logic [AW-1:0]   rf_wadr;
   logic [DW-1:0]   rf_wdata;
   logic [CW-1:0]   conflict_cnt;
`ifdef WB_BYPASS_EN
   logic [AW-1:0]   lookup_adr = '0;
   logic            fwd_hit;
   logic [DW-1:0]   fwd_data;
`endif

   regfile_wb_arbiter #(.N_REQ(N), .ADR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_adr      (req_adr),
      .req_data     (req_data),
      .rf_we        (rf_we),
      .rf_wadr      (rf_wadr),
      .rf_wdata     (rf_wdata),
      .busy         (busy),
      .conflict_cnt (conflict_cnt)
`ifdef WB_BYPASS_EN
     ,.lookup_adr   (lookup_adr)
     ,.fwd_hit      (fwd_hit)
     ,.fwd_data     (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   // requester drive state
   logic          v [N];
   logic [AW-1:0] a [N];
   logic [DW-1:0] d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = v[i];
         req_adr[i*AW +: AW]   = a[i];
         req_data[i*DW +: DW]  = d[i];
      end
   end

   // reference model state
   bit          m_pend [N];
   wb_entry_t   m_slot [N];
   int          m_ptr;
   bit          m_we;
   wb_entry_t   m_out;
   int          m_cnt;
   bit [N-1:0]  acc_last;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0;
      m_we  = 0;
      m_out = '0;
      m_cnt = 0;
   endtask

   // Pick the next slot to drain: search from the pointer, but a slot never overtakes
   // a lower-index pending slot that targets the same register.
   function automatic int model_grant();
      int g = -1;
      for (int k = 0; k < N; k++) begin
         int idx = (m_ptr + k) % N;
         bit shadow = 0;
         for (int j = 0; j < idx; j++)
            if (m_pend[j] && m_slot[j].adr == m_slot[idx].adr) shadow = 1;
         if (g < 0 && m_pend[idx] && !shadow) g = idx;
      end
      return g;
   endfunction

   // Check the current cycle against the model, advance the model, clock once.
   task automatic step();
      int g;
      int npend;
      logic [N-1:0] exp_ready;
      logic exp_busy;
      g = model_grant();
      npend = 0;
      exp_busy = 0;
      for (int i = 0; i < N; i++) begin
         exp_ready[i] = !m_pend[i] || (g == i);
         if (m_pend[i]) begin npend++; exp_busy = 1; end
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(exp_busy));
      check("rf_we", 64'(rf_we), 64'(m_we));
      check("rf_wadr", 64'(rf_wadr), 64'(m_out.adr));
      check("rf_wdata", 64'(rf_wdata), 64'(m_out.data));
      check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

      if (npend >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
      m_we = (g >= 0);
      if (g >= 0) begin
         m_out = m_slot[g];
         m_ptr = (g + 1) % N;
         m_pend[g] = 0;
      end
      acc_last = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i] && exp_ready[i]) begin
            acc_last[i] = 1;
            m_pend[i] = (a[i] != 0);
            m_slot[i].adr  = a[i];
            m_slot[i].data = d[i];
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc_last[i]) v[i] = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      for (int i = 0; i < N; i++) v[i] = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   int wcount;

   initial begin
      for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = 5'd1; d[i] = '0; end
      model_reset();

      // 1: ready during reset, first write latency
      #3;
      check("rst_ready", 64'(req_ready), 64'(3'b111));
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_cnt", 64'(conflict_cnt), 64'd0);
      v[1] = 0; v[2] = 0;
      a[0] = 5'd5; d[0] = 32'h11;
      @(posedge clk); #1;
      rst_n = 1;
      step();
      step();
      check("t1_we", 64'(rf_we), 64'd1);
      check("t1_wadr", 64'(rf_wadr), 64'd5);
      check("t1_wdata", 64'(rf_wdata), 64'h11);

      // 2: three simultaneous accepts drain in order r1, r2, r3
      do_reset();
      for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = AW'(i + 1); d[i] = 32'h100 + i; end
      step();
      for (int k = 1; k <= 3; k++) begin
         step();
         check("t2_we", 64'(rf_we), 64'd1);
         check("t2_wadr", 64'(rf_wadr), 64'(k));
      end
      check("t2_busy", 64'(busy), 64'd0);
      check("t2_cnt", 64'(conflict_cnt), 64'd2);

      // 3: requester 1 streams r4..r9
      wcount = 0;
      for (int k = 0; k < 8; k++) begin
         if (k < 6) begin v[1] = 1; a[1] = AW'(4 + k); d[1] = 32'hA000 + k; end
         if (k < 6) check("t3_ready", 64'(req_ready[1]), 64'd1);
         step();
         if (rf_we) begin
            check("t3_wadr", 64'(rf_wadr), 64'(3 + k));
            wcount++;
         end
      end
      check("t3_writes", 64'(wcount), 64'd6);

      // 4: same register from requesters 0 and 2, then a write to r0
      v[0] = 1; a[0] = 5'd7; d[0] = 32'hA;
      v[2] = 1; a[2] = 5'd7; d[2] = 32'hB;
      step();
      step();
      check("t4_first", 64'(rf_wdata), 64'hA);
      step();
      check("t4_second", 64'(rf_wdata), 64'hB);
      check("t4_wadr", 64'(rf_wadr), 64'd7);
      v[0] = 1; a[0] = 5'd0; d[0] = 32'hFF;
      step();
      check("t4_r0_acc", 64'(acc_last[0]), 64'd1);
      check("t4_r0_busy", 64'(busy), 64'd0);
      step();
      check("t4_r0_we", 64'(rf_we), 64'd0);

`ifdef WB_BYPASS_EN
      // 6: forwarding from a pending slot
      v[2] = 1; a[2] = 5'd9; d[2] = 32'hC0DE;
      step();
      lookup_adr = 5'd9;
      #1;
      check("t6_hit", 64'(fwd_hit), 64'd1);
      check("t6_data", 64'(fwd_data), 64'hC0DE);
      lookup_adr = 5'd0;
      #1;
      check("t6_r0_hit", 64'(fwd_hit), 64'd0);
      check("t6_r0_data", 64'(fwd_data), 64'd0);
      step();
`endif

      // 5: asynchronous reset with two slots pending
      for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = AW'(10 + i); d[i] = 32'h500 + i; end
      step();
      step();
      check("t5_we_before", 64'(rf_we), 64'd1);
      #2;
      rst_n = 0;
      #1;
      check("t5_we_drop", 64'(rf_we), 64'd0);
      check("t5_busy_drop", 64'(busy), 64'd0);
      for (int i = 0; i < N; i++) v[i] = 0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      wcount = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (rf_we) wcount++;
      end
      check("t5_no_write", 64'(wcount), 64'd0);

      // random traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 1) == 1) begin
               v[i] = 1;
               a[i] = AW'($urandom_range(0, 7));
               d[i] = $urandom;
            end
         end
         step();
      end
      for (int i = 0; i < N; i++) v[i] = 0;
      for (int c = 0; c < 6; c++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
